// File: rtl/lock_reset_sequencer.sv
// Reset sequencer for the GL0 domain: synchronises CCC lock and the board button,
// filters them, then releases fabric reset followed by processor reset.
module lock_reset_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_FILTER  = 16,
  parameter int FABRIC_DELAY = 64,
  parameter int CPU_DELAY    = 256
) (
  input  logic       HCLK,
  input  logic       HRESETN,
  input  logic       PLL_LOCK,
  input  logic       EXT_RESET_N,
  input  logic       SOFT_RESET,
  input  logic       CLEAR_LOST,
  output logic       FABRIC_RESET_N,
  output logic       CPU_RESET_N,
  output logic       LOCK_LOST,
  output logic [7:0] LOSS_COUNT,
  output logic [1:0] SEQ_STATE
);

  localparam logic [1:0] ST_WAIT_LOCK   = 2'd0;
  localparam logic [1:0] ST_FABRIC_HOLD = 2'd1;
  localparam logic [1:0] ST_CPU_HOLD    = 2'd2;
  localparam logic [1:0] ST_RUN         = 2'd3;

  localparam logic [15:0] FILTER_LAST = 16'(LOCK_FILTER - 1);
  localparam logic [15:0] FABRIC_LAST = 16'(FABRIC_DELAY - 1);
  localparam logic [15:0] CPU_LAST    = 16'(CPU_DELAY - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] lock_sync_r;
  logic [SYNC_STAGES-1:0] ext_sync_r;
  logic [1:0]             state_r;
  logic [15:0]            count_r;
  logic                   fabric_rst_n_r;
  logic                   cpu_rst_n_r;
  logic                   lock_lost_r;
  logic [7:0]             loss_count_r;

  logic                   lock_s;
  logic                   ext_s;
  logic                   qual_s;
  logic                   abort_s;
  logic                   loss_event_s;
  logic [1:0]             next_state_s;
  logic [15:0]            next_count_s;

  // Input synchronisers for the two asynchronous inputs
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      lock_sync_r <= '0;
      ext_sync_r  <= '0;
    end else begin
      lock_sync_r <= {lock_sync_r[SYNC_STAGES-2:0], PLL_LOCK};
      ext_sync_r  <= {ext_sync_r[SYNC_STAGES-2:0], EXT_RESET_N};
    end
  end

  assign lock_s       = lock_sync_r[SYNC_STAGES-1];
  assign ext_s        = ext_sync_r[SYNC_STAGES-1];
  assign qual_s       = lock_s & ext_s;
  assign abort_s      = (state_r != ST_WAIT_LOCK) && (!lock_s || !ext_s || SOFT_RESET);
  assign loss_event_s = (state_r != ST_WAIT_LOCK) && !lock_s;

  // Next-state and shared-counter logic; abort outranks counter completion
  always_comb begin
    next_state_s = state_r;
    next_count_s = count_r;
    if (abort_s) begin
      next_state_s = ST_WAIT_LOCK;
      next_count_s = 16'd0;
    end else begin
      case (state_r)
        ST_WAIT_LOCK: begin
          if (SOFT_RESET || !qual_s) begin
            next_count_s = 16'd0;
          end else if (count_r == FILTER_LAST) begin
            next_state_s = ST_FABRIC_HOLD;
            next_count_s = 16'd0;
          end else begin
            next_count_s = count_r + 16'd1;
          end
        end
        ST_FABRIC_HOLD: begin
          if (count_r == FABRIC_LAST) begin
            next_state_s = ST_CPU_HOLD;
            next_count_s = 16'd0;
          end else begin
            next_count_s = count_r + 16'd1;
          end
        end
        ST_CPU_HOLD: begin
          if (count_r == CPU_LAST) begin
            next_state_s = ST_RUN;
            next_count_s = 16'd0;
          end else begin
            next_count_s = count_r + 16'd1;
          end
        end
        ST_RUN: begin
          next_count_s = 16'd0;
        end
        default: begin
          next_state_s = ST_WAIT_LOCK;
          next_count_s = 16'd0;
        end
      endcase
    end
  end

  // State, counter and reset outputs; resets decode the next state so they track it
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_r        <= ST_WAIT_LOCK;
      count_r        <= 16'd0;
      fabric_rst_n_r <= 1'b0;
      cpu_rst_n_r    <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      count_r        <= next_count_s;
      fabric_rst_n_r <= (next_state_s == ST_CPU_HOLD) || (next_state_s == ST_RUN);
      cpu_rst_n_r    <= (next_state_s == ST_RUN);
    end
  end

  // Lock-loss log; a new event beats a coincident clear
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      lock_lost_r  <= 1'b0;
      loss_count_r <= 8'd0;
    end else if (loss_event_s) begin
      lock_lost_r  <= 1'b1;
      loss_count_r <= CLEAR_LOST ? 8'd1 : sat_inc8(loss_count_r);
    end else if (CLEAR_LOST) begin
      lock_lost_r  <= 1'b0;
      loss_count_r <= 8'd0;
    end else begin
      lock_lost_r  <= lock_lost_r;
      loss_count_r <= loss_count_r;
    end
  end

  assign FABRIC_RESET_N = fabric_rst_n_r;
  assign CPU_RESET_N    = cpu_rst_n_r;
  assign LOCK_LOST      = lock_lost_r;
  assign LOSS_COUNT     = loss_count_r;
  assign SEQ_STATE      = state_r;

endmodule

// File: tb/tb_lock_reset_sequencer.sv
// Scoreboard bench for lock_reset_sequencer: stimulus queues expected output
// snapshots per edge, a negedge monitor pops and compares them.
module tb_lock_reset_sequencer;

  logic       HCLK = 1'b0;
  logic       HRESETN;
  logic       PLL_LOCK;
  logic       EXT_RESET_N;
  logic       SOFT_RESET;
  logic       CLEAR_LOST;
  logic       FABRIC_RESET_N;
  logic       CPU_RESET_N;
  logic       LOCK_LOST;
  logic [7:0] LOSS_COUNT;
  logic [1:0] SEQ_STATE;

  lock_reset_sequencer dut (
    .HCLK           (HCLK),
    .HRESETN        (HRESETN),
    .PLL_LOCK       (PLL_LOCK),
    .EXT_RESET_N    (EXT_RESET_N),
    .SOFT_RESET     (SOFT_RESET),
    .CLEAR_LOST     (CLEAR_LOST),
    .FABRIC_RESET_N (FABRIC_RESET_N),
    .CPU_RESET_N    (CPU_RESET_N),
    .LOCK_LOST      (LOCK_LOST),
    .LOSS_COUNT     (LOSS_COUNT),
    .SEQ_STATE      (SEQ_STATE)
  );

  always #5 HCLK = ~HCLK;

  // Edges counted since the last HRESETN release
  int edge_n = 0;
  always @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) edge_n <= 0;
    else          edge_n <= edge_n + 1;
  end

  int          exp_en_q[$];
  logic [12:0] exp_v_q[$];
  string       exp_name_q[$];
  int          total = 0;
  int          bad = 0;

  task automatic expect_at(input int en, input string nm, input logic fab, input logic cpu,
                           input logic [1:0] st, input logic lost, input logic [7:0] cnt);
    exp_en_q.push_back(en);
    exp_v_q.push_back({fab, cpu, st, lost, cnt});
    exp_name_q.push_back(nm);
  endtask

  task automatic goto_edge(input int n);
    while (edge_n < n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  // Monitor: compare the DUT outputs against every snapshot due at this edge
  always @(negedge HCLK) begin
    logic [12:0] act;
    act = {FABRIC_RESET_N, CPU_RESET_N, SEQ_STATE, LOCK_LOST, LOSS_COUNT};
    while (exp_en_q.size() > 0 && exp_en_q[0] <= edge_n) begin
      total++;
      if (exp_en_q[0] < edge_n) begin
        bad++;
        $display("FAIL %s: check for edge %0d skipped, now at edge %0d", exp_name_q[0], exp_en_q[0], edge_n);
      end else if (act !== exp_v_q[0]) begin
        bad++;
        $display("FAIL %s @edge %0d: got fab=%b cpu=%b st=%0d lost=%b cnt=%0d, want fab=%b cpu=%b st=%0d lost=%b cnt=%0d",
                 exp_name_q[0], edge_n, act[12], act[11], act[10:9], act[8], act[7:0],
                 exp_v_q[0][12], exp_v_q[0][11], exp_v_q[0][10:9], exp_v_q[0][8], exp_v_q[0][7:0]);
      end
      void'(exp_en_q.pop_front());
      void'(exp_v_q.pop_front());
      void'(exp_name_q.pop_front());
    end
  end

  initial begin
    HRESETN     = 1'b0;
    PLL_LOCK    = 1'b1;
    EXT_RESET_N = 1'b1;
    SOFT_RESET  = 1'b0;
    CLEAR_LOST  = 1'b0;

    expect_at(0,   "reset",      1'b0, 1'b0, 2'd0, 1'b0, 8'd0);
    expect_at(17,  "pu_wait",    1'b0, 1'b0, 2'd0, 1'b0, 8'd0);
    expect_at(18,  "pu_fhold",   1'b0, 1'b0, 2'd1, 1'b0, 8'd0);
    expect_at(81,  "pu_fab_lo",  1'b0, 1'b0, 2'd1, 1'b0, 8'd0);
    expect_at(82,  "pu_fab_hi",  1'b1, 1'b0, 2'd2, 1'b0, 8'd0);
    expect_at(337, "pu_cpu_lo",  1'b1, 1'b0, 2'd2, 1'b0, 8'd0);
    expect_at(338, "pu_cpu_hi",  1'b1, 1'b1, 2'd3, 1'b0, 8'd0);
    expect_at(399, "pu_run",     1'b1, 1'b1, 2'd3, 1'b0, 8'd0);
    #17 HRESETN = 1'b1;

    // Lock loss in RUN, then a one-cycle glitch while refiltering
    goto_edge(400);
    PLL_LOCK = 1'b0;
    expect_at(402, "loss_pre",   1'b1, 1'b1, 2'd3, 1'b0, 8'd0);
    expect_at(403, "loss_abort", 1'b0, 1'b0, 2'd0, 1'b1, 8'd1);
    expect_at(423, "glitch",     1'b0, 1'b0, 2'd0, 1'b1, 8'd1);
    expect_at(438, "rf_wait",    1'b0, 1'b0, 2'd0, 1'b1, 8'd1);
    expect_at(439, "rf_fhold",   1'b0, 1'b0, 2'd1, 1'b1, 8'd1);
    expect_at(502, "rf_fab_lo",  1'b0, 1'b0, 2'd1, 1'b1, 8'd1);
    expect_at(503, "rf_fab_hi",  1'b1, 1'b0, 2'd2, 1'b1, 8'd1);
    expect_at(758, "rf_cpu_lo",  1'b1, 1'b0, 2'd2, 1'b1, 8'd1);
    expect_at(759, "rf_cpu_hi",  1'b1, 1'b1, 2'd3, 1'b1, 8'd1);
    goto_edge(410);
    PLL_LOCK = 1'b1;
    goto_edge(420);
    PLL_LOCK = 1'b0;
    goto_edge(421);
    PLL_LOCK = 1'b1;

    // Soft reset from RUN, then soft reset and button in CPU_HOLD
    goto_edge(800);
    SOFT_RESET = 1'b1;
    expect_at(801, "soft_run",   1'b0, 1'b0, 2'd0, 1'b1, 8'd1);
    expect_at(817, "soft_fh",    1'b0, 1'b0, 2'd1, 1'b1, 8'd1);
    expect_at(900, "soft_ch",    1'b1, 1'b0, 2'd2, 1'b1, 8'd1);
    expect_at(901, "soft_abort", 1'b0, 1'b0, 2'd0, 1'b1, 8'd1);
    goto_edge(801);
    SOFT_RESET = 1'b0;
    goto_edge(900);
    SOFT_RESET = 1'b1;
    goto_edge(901);
    SOFT_RESET = 1'b0;
    expect_at(981,  "btn_ch",    1'b1, 1'b0, 2'd2, 1'b1, 8'd1);
    expect_at(1002, "btn_pre",   1'b1, 1'b0, 2'd2, 1'b1, 8'd1);
    expect_at(1003, "btn_abort", 1'b0, 1'b0, 2'd0, 1'b1, 8'd1);
    expect_at(1027, "btn_wait",  1'b0, 1'b0, 2'd0, 1'b1, 8'd1);
    expect_at(1028, "btn_fh",    1'b0, 1'b0, 2'd1, 1'b1, 8'd1);
    expect_at(1092, "btn_fab",   1'b1, 1'b0, 2'd2, 1'b1, 8'd1);
    expect_at(1348, "btn_run",   1'b1, 1'b1, 2'd3, 1'b1, 8'd1);
    goto_edge(1000);
    EXT_RESET_N = 1'b0;
    goto_edge(1010);
    EXT_RESET_N = 1'b1;

    // 300 lock-loss events, each caught in FABRIC_HOLD after a fresh filter
    for (int i = 0; i < 300; i++) begin
      int b;
      b = 1400 + 22 * i;
      goto_edge(b);
      PLL_LOCK = 1'b0;
      expect_at(b + 3, "sat", 1'b0, 1'b0, 2'd0, 1'b1, (i + 2 > 255) ? 8'd255 : 8'(i + 2));
      goto_edge(b + 4);
      PLL_LOCK = 1'b1;
    end
    expect_at(8005, "sat_fh",    1'b0, 1'b0, 2'd1, 1'b1, 8'd255);
    expect_at(8011, "clr_alone", 1'b0, 1'b0, 2'd1, 1'b0, 8'd0);
    expect_at(8022, "clr_pre",   1'b0, 1'b0, 2'd1, 1'b0, 8'd0);
    expect_at(8023, "clr_event", 1'b0, 1'b0, 2'd0, 1'b1, 8'd1);
    expect_at(8199, "ar_pre",    1'b1, 1'b0, 2'd2, 1'b1, 8'd1);
    goto_edge(8010);
    CLEAR_LOST = 1'b1;
    goto_edge(8011);
    CLEAR_LOST = 1'b0;
    goto_edge(8020);
    PLL_LOCK = 1'b0;
    goto_edge(8022);
    CLEAR_LOST = 1'b1;
    goto_edge(8023);
    CLEAR_LOST = 1'b0;
    goto_edge(8030);
    PLL_LOCK = 1'b1;

    // Asynchronous reset while in CPU_HOLD
    goto_edge(8200);
    HRESETN = 1'b0;
    expect_at(0,   "ar_reset",   1'b0, 1'b0, 2'd0, 1'b0, 8'd0);
    expect_at(17,  "ar_wait",    1'b0, 1'b0, 2'd0, 1'b0, 8'd0);
    expect_at(18,  "ar_fh",      1'b0, 1'b0, 2'd1, 1'b0, 8'd0);
    expect_at(82,  "ar_fab",     1'b1, 1'b0, 2'd2, 1'b0, 8'd0);
    expect_at(337, "ar_cpu_lo",  1'b1, 1'b0, 2'd2, 1'b0, 8'd0);
    expect_at(338, "ar_cpu_hi",  1'b1, 1'b1, 2'd3, 1'b0, 8'd0);
    #7 HRESETN = 1'b1;

    // SOFT_RESET held high pins the FSM in WAIT_LOCK
    goto_edge(400);
    SOFT_RESET = 1'b1;
    expect_at(401, "hold_abort", 1'b0, 1'b0, 2'd0, 1'b0, 8'd0);
    expect_at(430, "hold_wait",  1'b0, 1'b0, 2'd0, 1'b0, 8'd0);
    expect_at(455, "hold_rel",   1'b0, 1'b0, 2'd0, 1'b0, 8'd0);
    expect_at(456, "hold_fh",    1'b0, 1'b0, 2'd1, 1'b0, 8'd0);
    goto_edge(440);
    SOFT_RESET = 1'b0;
    goto_edge(470);

    for (int k = 0; k < 100 && exp_en_q.size() > 0; k++) @(negedge HCLK);
    if (exp_en_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d checks still pending, want 0", exp_en_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lock_reset_sequencer.md
# lock_reset_sequencer

Reset sequencer sitting directly downstream of the fabric CCC, in the GL0 clock domain. It synchronises the CCC `LOCK` output and the board reset button, qualifies them with a stability filter, and releases fabric reset and then processor reset in a fixed order with programmable delays. Loss of lock, a button press or a soft-reset request re-asserts both resets. Lock-loss events are logged for debug.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on each async input (legal 2..4).
- `LOCK_FILTER`, 16: consecutive qualifying cycles required before the sequence starts (1..65535).
- `FABRIC_DELAY`, 64: cycles from the end of filtering to `FABRIC_RESET_N` release (1..65535).
- `CPU_DELAY`, 256: cycles from `FABRIC_RESET_N` release to `CPU_RESET_N` release (1..65535).

Ports:
- `HCLK` in 1: GL0 clock; the block's only clock.
- `HRESETN` in 1: device power-on reset. Asynchronous, active-low.
- `PLL_LOCK` in 1: CCC `LOCK`. Asynchronous to `HCLK`.
- `EXT_RESET_N` in 1: board push-button, active-low. Asynchronous.
- `SOFT_RESET` in 1: synchronous single-cycle request, active-high.
- `CLEAR_LOST` in 1: synchronous, active-high; clears the loss log.
- `FABRIC_RESET_N` out 1: reset for the AHB fabric and peripherals. Active-low, registered.
- `CPU_RESET_N` out 1: reset for the MIV_RV32IMA core. Active-low, registered.
- `LOCK_LOST` out 1: sticky flag, set when lock is lost after filtering has completed.
- `LOSS_COUNT` out 8: number of lock-loss events, saturating.
- `SEQ_STATE` out 2: current state encoding, for debug.

## Operation
Input synchronisation:
- `PLL_LOCK` and `EXT_RESET_N` each pass through `SYNC_STAGES` flops.
- The synchroniser flops reset to 0 on `HRESETN`.
- The resulting signals are `lock_s` and `ext_s`.
- `qual = lock_s & ext_s`.

State machine, with `SEQ_STATE` encoding:
- WAIT_LOCK (0): counts consecutive cycles with `qual`=1.
  - The counter clears on any cycle with `qual`=0 or `SOFT_RESET`=1.
  - When the count reaches `LOCK_FILTER`, go to FABRIC_HOLD.
- FABRIC_HOLD (1): counts `FABRIC_DELAY` cycles, then goes to CPU_HOLD.
- CPU_HOLD (2): counts `CPU_DELAY` cycles, then goes to RUN.
- RUN (3): holds indefinitely.

Abort rule:
- In FABRIC_HOLD, CPU_HOLD or RUN, any of `lock_s`=0, `ext_s`=0 or `SOFT_RESET`=1 sends the FSM to WAIT_LOCK on that edge.
- This check has priority over counter-completion transitions.

Shared counter:
- One 16-bit counter serves all states and clears on every state transition.
- Within a state it never wraps. The terminal compare is `count == PARAM-1` on the qualifying cycle.

Outputs:
- Both resets are registered and decoded from the next state, so they change on the same edge as the state register.
- `FABRIC_RESET_N` = 1 iff the state is CPU_HOLD or RUN.
- `CPU_RESET_N` = 1 iff the state is RUN.
- Resets assert on the abort edge and never glitch.

Loss logging:
- A lock-loss event is an abort caused by `lock_s`=0 in a state other than WAIT_LOCK.
- On an event, `LOCK_LOST` is set and `LOSS_COUNT` increments, saturating at 255.
- Aborts caused by `ext_s` or `SOFT_RESET` alone are not logged.
- `CLEAR_LOST` clears both `LOCK_LOST` and `LOSS_COUNT`. If `CLEAR_LOST` coincides with a new event, the event wins: the flag stays set and the count becomes 1.

Reset values on `HRESETN`=0:
- State WAIT_LOCK, counter 0.
- `FABRIC_RESET_N`=0, `CPU_RESET_N`=0.
- `LOCK_LOST`=0, `LOSS_COUNT`=0, `SEQ_STATE`=0.
- Assertion of `HRESETN` at any point takes effect immediately and asynchronously. Release re-enters WAIT_LOCK.

## Timing
- With `PLL_LOCK` and `EXT_RESET_N` stable high before edge 1:
  - The FSM enters FABRIC_HOLD after edge `SYNC_STAGES+LOCK_FILTER`.
  - `FABRIC_RESET_N` rises after edge `SYNC_STAGES+LOCK_FILTER+FABRIC_DELAY`.
  - `CPU_RESET_N` rises `CPU_DELAY` edges after that.
  - With default parameters these are edges 18, 82 and 338.
- Abort latency from a raw input fall to reset assertion is `SYNC_STAGES+1` edges.
- `SOFT_RESET` abort latency is 1 edge.
- A glitch on `lock_s` lasting one cycle during WAIT_LOCK restarts the filter from 0.
- `SOFT_RESET` held high keeps the FSM in WAIT_LOCK with the counter at 0.

## Test plan
- **Power-up:** default parameters; `PLL_LOCK`=`EXT_RESET_N`=1 from edge 0 → `FABRIC_RESET_N` rises at edge 82 and `CPU_RESET_N` at edge 338; `SEQ_STATE` reads 0→1→2→3; `LOCK_LOST`=0.
- **Filter restart:** `PLL_LOCK` low for 1 cycle around edge 10 → the sequence is delayed so that `FABRIC_RESET_N` rises exactly 16+64 edges after the first qualifying edge following the glitch; no log entry.
- **Lock loss in RUN:** `PLL_LOCK` falls at edge 400 → both resets are 0 by edge 403; `LOCK_LOST`=1; `LOSS_COUNT`=1; when lock returns, the full sequence replays.
- **Button and soft reset in CPU_HOLD:** each sends the FSM to WAIT_LOCK (`SOFT_RESET` in 1 edge, the button in 3 edges) with `FABRIC_RESET_N`=0; `LOSS_COUNT` is unchanged.
- **Saturation and clear:** 300 lock-loss events → `LOSS_COUNT`=255; `CLEAR_LOST` asserted alone → 0/0; `CLEAR_LOST` on the same edge as an event → `LOCK_LOST`=1, `LOSS_COUNT`=1.
- **Async reset mid-sequence:** `HRESETN` pulsed low at edge 200 (in CPU_HOLD) → all outputs return to reset values immediately; after release, `CPU_RESET_N` rises 338 edges later.
